div_rem_sequencer: RTL and testbench
====================================

Name: div_rem_sequencer

Overview:
- Multi-cycle controller and datapath for the RV32M DIV/DIVU/REM/REMU ops issued from the EXE stage.
- Latches operands, runs a radix-2 restoring divide and applies RISC-V sign, divide-by-zero and overflow rules.
- Generates exe_stall_div_rem for the pipeline stall/flush logic, which holds IF/ID and bubbles EX/MEM.
- Honours pipeline kill (cancel) and memory-wait freeze (hold).

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
start  in  1  valid div/rem instruction currently in EXE
op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1_data  in  XLEN  dividend
rs2_data  in  XLEN  divisor
cancel  in  1  instruction in EXE killed (ind_flush: context switch / finish)
hold  in  1  EXE frozen by L2 data wait (exe_stall)
exe_stall_div_rem  out  1  stall request to pipeline control
result  out  XLEN  quotient or remainder
result_valid  out  1  result present for the instruction in EXE
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, counter 0, result 0, result_valid 0, busy 0. Reset mid-operation aborts with no result.
- States: IDLE, CALC, DONE.
- IDLE, start=1, cancel=0:
  - Latch operands and op.
  - Compute |a|,|b| for signed ops. Record neg_q = sign(a)^sign(b), neg_r = sign(a).
  - Special cases (rs2=0, or signed with rs1=0x80000000 and rs2=0xFFFFFFFF): load the final result and go to DONE.
  - Otherwise: clear remainder, counter=0, go to CALC.
- CALC, one iteration per cycle:
  - rem' = {rem[XLEN-2:0], q[XLEN-1]}; q shifts left.
  - If rem' >= divisor: rem' -= divisor and q[0]=1.
  - After iteration XLEN (counter == XLEN-1), apply sign correction: negate q if neg_q, negate rem if neg_r.
  - Select q (DIV/DIVU) or rem (REM/REMU) into result. Go to DONE.
  - Iteration continues regardless of hold.
- DONE:
  - result_valid=1.
  - hold=1: remain in DONE with result stable.
  - hold=0: go to IDLE. start is ignored in DONE, because the same instruction is still in EXE.
- exe_stall_div_rem is combinational: (IDLE & start & !cancel) | CALC. It is low in DONE so the instruction advances that cycle.
- Normal latency: start cycle plus XLEN CALC cycles means 33 stall cycles, then result_valid on the next cycle. Special-case latency: 1 stall cycle, then DONE.
- Back-to-back: a new start in the IDLE cycle right after DONE is accepted normally.
- cancel=1 in any state: next state IDLE, result_valid 0, result unchanged. cancel takes priority over start and hold. Stall drops the same cycle in IDLE, the next cycle in CALC.
- Special-case values:
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Signed overflow: quotient = 0x80000000; remainder = 0.
- Unsigned ops: no abs or negation.
- All arithmetic is XLEN bits; the subtraction compare uses an XLEN+1-bit difference.

Decomposition:
- Shared package (rv32m_pkg):
  - op encodings OP_DIV/OP_DIVU/OP_REM/OP_REMU.
  - state enum IDLE/CALC/DONE.
  - constants INT_MIN and ALL_ONES.
- Sub-module div_rem_step: combinational single restoring iteration. Inputs: rem, q, divisor. Outputs: rem_next, q_next.
- The sequencer owns the FSM, counter, sign handling and special cases.

Test Plan:
- DIVU 100/7, hold=0 -> stall high exactly 33 cycles; next cycle result=14, result_valid=1 for 1 cycle; REMU same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> -3; REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with 1 stall cycle then result_valid.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0, 1-cycle latency.
- DIVU 1000/3: cancel pulsed at CALC iteration 10 -> IDLE next cycle, no result_valid, stall low; then start=1 with cancel=1 in IDLE -> stall 0, stays IDLE.
- DIVU 9/3 with hold=1 for 3 cycles upon reaching DONE -> result=3, result_valid held 3 cycles, then IDLE; immediate second DIVU 8/2 accepted -> result 4.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared encodings and constants for the RV32M divide/remainder sequencer.
package rv32m_pkg;

  // funct3[1:0] encodings of the RV32M divide family
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Most negative signed value and the all-ones pattern for a 32-bit datapath
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_rem_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// trial-subtract the divisor and record the quotient bit.
module div_rem_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] q_next
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;

  // The shifted partial remainder can need XLEN+1 bits when the divisor is
  // large, so the trial subtraction is carried out one bit wider.
  always_comb begin
    shifted_s = {rem, q[XLEN-1]};
    diff_s    = shifted_s - {1'b0, divisor};
    if (diff_s[XLEN] == 1'b0) begin
      rem_next = diff_s[XLEN-1:0];
      q_next   = {q[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted_s[XLEN-1:0];
      q_next   = {q[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_rem_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit driven from the EXE stage.
// Handles operand latching, sign fix-up, divide-by-zero/overflow shortcuts,
// pipeline kill (cancel) and EXE freeze (hold).
module div_rem_sequencer
  import rv32m_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            cancel,
  input  logic            hold,
  output logic            exe_stall_div_rem,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   divisor_q;
  logic              is_rem_q;
  logic              neg_q_q;
  logic              neg_r_q;
  logic [XLEN-1:0]   result_q;

  logic              is_signed_s;
  logic              is_rem_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   abs_a_s;
  logic [XLEN-1:0]   abs_b_s;
  logic              div0_s;
  logic              ovf_s;
  logic [XLEN-1:0]   special_res_s;
  logic [XLEN-1:0]   rem_next_s;
  logic [XLEN-1:0]   q_next_s;
  logic [XLEN-1:0]   final_res_s;
  logic              last_iter_s;

  div_rem_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .q        (quo_q),
    .divisor  (divisor_q),
    .rem_next (rem_next_s),
    .q_next   (q_next_s)
  );

  // Issue-time decode: operand magnitudes and the two shortcut cases
  always_comb begin
    is_signed_s = (op == OP_DIV) || (op == OP_REM);
    is_rem_s    = (op == OP_REM) || (op == OP_REMU);
    a_neg_s     = is_signed_s & rs1_data[XLEN-1];
    b_neg_s     = is_signed_s & rs2_data[XLEN-1];
    abs_a_s     = a_neg_s ? (~rs1_data + {{(XLEN-1){1'b0}}, 1'b1}) : rs1_data;
    abs_b_s     = b_neg_s ? (~rs2_data + {{(XLEN-1){1'b0}}, 1'b1}) : rs2_data;
    div0_s      = (rs2_data == {XLEN{1'b0}});
    ovf_s       = is_signed_s && (rs1_data == INT_MIN) && (rs2_data == ALL_ONES);
    if (div0_s) begin
      special_res_s = is_rem_s ? rs1_data : ALL_ONES;
    end else if (ovf_s) begin
      special_res_s = is_rem_s ? {XLEN{1'b0}} : INT_MIN;
    end else begin
      special_res_s = {XLEN{1'b0}};
    end
  end

  // Final-iteration sign correction and quotient/remainder selection
  always_comb begin
    last_iter_s = (cnt_q == CNT_W'(XLEN - 1));
    if (is_rem_q) begin
      final_res_s = neg_r_q ? (~rem_next_s + {{(XLEN-1){1'b0}}, 1'b1}) : rem_next_s;
    end else begin
      final_res_s = neg_q_q ? (~q_next_s + {{(XLEN-1){1'b0}}, 1'b1}) : q_next_s;
    end
  end

  // Control FSM and datapath registers; cancel overrides everything but reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      rem_q     <= {XLEN{1'b0}};
      quo_q     <= {XLEN{1'b0}};
      divisor_q <= {XLEN{1'b0}};
      is_rem_q  <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      result_q  <= {XLEN{1'b0}};
    end else if (cancel) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            is_rem_q <= is_rem_s;
            neg_q_q  <= a_neg_s ^ b_neg_s;
            neg_r_q  <= a_neg_s;
            if (div0_s || ovf_s) begin
              result_q <= special_res_s;
              state_q  <= DONE;
            end else begin
              rem_q     <= {XLEN{1'b0}};
              quo_q     <= abs_a_s;
              divisor_q <= abs_b_s;
              cnt_q     <= {CNT_W{1'b0}};
              state_q   <= CALC;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          rem_q <= rem_next_s;
          quo_q <= q_next_s;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter_s) begin
            result_q <= final_res_s;
            state_q  <= DONE;
          end else begin
            state_q <= CALC;
          end
        end
        DONE: begin
          // start is ignored here: the same instruction is still in EXE
          if (!hold) begin
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall must rise in the issue cycle itself, so it is decoded from state and inputs
  always_comb begin
    exe_stall_div_rem = ((state_q == IDLE) && start && !cancel) || (state_q == CALC);
    result            = result_q;
    result_valid      = (state_q == DONE);
    busy              = (state_q != IDLE);
  end

endmodule

// File: tb/tb_div_rem_sequencer.sv
// Directed, table-driven bench for div_rem_sequencer plus hand-written
// sequences for cancel, hold, back-to-back issue and mid-operation reset.
module tb_div_rem_sequencer;
  import rv32m_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        cancel;
  logic        hold;
  logic        exe_stall_div_rem;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;

  int checks;
  int errors;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stalls;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  div_rem_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .op                (op),
    .rs1_data          (rs1_data),
    .rs2_data          (rs2_data),
    .cancel            (cancel),
    .hold              (hold),
    .exe_stall_div_rem (exe_stall_div_rem),
    .result            (result),
    .result_valid      (result_valid),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at negedge with inputs already applied; returns at negedge+1 of the valid cycle.
  task automatic wait_valid(output int stalls, output bit seen);
    stalls = 0;
    seen   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
      if (exe_stall_div_rem) stalls++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int stalls;
    bit seen;
    op       = v.op;
    rs1_data = v.a;
    rs2_data = v.b;
    start    = 1'b1;
    wait_valid(stalls, seen);
    check({name, " valid_seen"}, {31'd0, seen}, 32'd1);
    check({name, " stall_cycles"}, stalls, v.stalls);
    check({name, " result"}, result, v.exp);
    start = 1'b0;
    @(negedge clk);
    #1;
    check({name, " valid_one_cycle"}, {31'd0, result_valid}, 32'd0);
    check({name, " back_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int stalls;
    bit seen;
    logic [31:0] last_res;

    checks = 0;
    errors = 0;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[5]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[6]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[7]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          1};
    vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          33};
    vecs[11] = '{OP_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          33};
    vecs[12] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[13] = '{OP_REM,  32'hFFFF_FFF8,  32'd3,          32'hFFFF_FFFE,  33};
    vecs[14] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};

    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    cancel   = 1'b0;
    hold     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset result", result, 32'd0);
    check("reset valid", {31'd0, result_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset stall", {31'd0, exe_stall_div_rem}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end
    last_res = vecs[NVEC-1].exp;

    // Cancel during CALC iteration 10, then start+cancel together in IDLE
    op       = OP_DIVU;
    rs1_data = 32'd1000;
    rs2_data = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    check("cancel busy_before", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    #1;
    check("cancel stall_in_calc", {31'd0, exe_stall_div_rem}, 32'd1);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    #1;
    check("cancel busy_after", {31'd0, busy}, 32'd0);
    check("cancel stall_after", {31'd0, exe_stall_div_rem}, 32'd0);
    check("cancel no_valid", {31'd0, result_valid}, 32'd0);
    check("cancel result_kept", result, last_res);
    start  = 1'b1;
    cancel = 1'b1;
    #1;
    check("start_cancel stall", {31'd0, exe_stall_div_rem}, 32'd0);
    @(negedge clk);
    #1;
    check("start_cancel idle", {31'd0, busy}, 32'd0);
    check("start_cancel no_valid", {31'd0, result_valid}, 32'd0);
    start  = 1'b0;
    cancel = 1'b0;
    @(negedge clk);

    // Hold in DONE keeps the result for 3 valid cycles, then back-to-back issue
    op       = OP_DIVU;
    rs1_data = 32'd9;
    rs2_data = 32'd3;
    start    = 1'b1;
    wait_valid(stalls, seen);
    check("hold valid_seen", {31'd0, seen}, 32'd1);
    check("hold stall_cycles", stalls, 33);
    check("hold result_c1", result, 32'd3);
    hold = 1'b1;
    @(negedge clk);
    #1;
    check("hold valid_c2", {31'd0, result_valid}, 32'd1);
    check("hold result_c2", result, 32'd3);
    check("hold stall_c2", {31'd0, exe_stall_div_rem}, 32'd0);
    @(negedge clk);
    #1;
    hold     = 1'b0;
    rs1_data = 32'd8;
    rs2_data = 32'd2;
    #1;
    check("hold valid_c3", {31'd0, result_valid}, 32'd1);
    check("hold result_c3", result, 32'd3);
    check("hold start_ignored", {31'd0, exe_stall_div_rem}, 32'd0);
    @(negedge clk);
    wait_valid(stalls, seen);
    check("b2b valid_seen", {31'd0, seen}, 32'd1);
    check("b2b stall_cycles", stalls, 33);
    check("b2b result", result, 32'd4);
    start = 1'b0;
    @(negedge clk);
    #1;
    check("b2b valid_one_cycle", {31'd0, result_valid}, 32'd0);

    // Reset mid-operation aborts without a result
    op       = OP_DIVU;
    rs1_data = 32'd77;
    rs2_data = 32'd5;
    start    = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset valid", {31'd0, result_valid}, 32'd0);
    check("midreset result", result, 32'd0);
    check("midreset stall", {31'd0, exe_stall_div_rem}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
